riscv_muldiv: RTL and testbench

RISCV_MULDIV -- requirements
Module: riscv_muldiv

---
 rtl/riscv_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_riscv_muldiv.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV M-extension multiply/divide unit.
// The unit performs one radix-2 step per cycle on operand magnitudes. It uses
// a 2*XLEN accumulator, followed by one sign-fix cycle and one done cycle.
// Latency is fixed at XLEN+2 cycles from an accepted start to the done pulse.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - request an operation (accepted only when idle)
//   funct3  - M-extension op (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   op_a    - rs1 operand (multiplicand / dividend)
//   op_b    - rs2 operand (multiplier / divisor)
//   flush   - abort any in-flight operation
//   busy    - operation in flight (calc and fix phases)
//   done    - single-cycle result-valid pulse
//   result  - last completed result
module riscv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic            bzero_q, bzero_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand signedness and magnitudes at accept time
  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] a_mag, b_mag;

  assign signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                    (funct3 == 3'b110);
  assign sign_a   = signed_a & op_a[XLEN-1];
  assign sign_b   = signed_b & op_b[XLEN-1];
  assign a_mag    = sign_a ? (~op_a + XLEN'(1)) : op_a;
  assign b_mag    = sign_b ? (~op_b + XLEN'(1)) : op_b;

  // Multiply step: conditionally add multiplicand into the high half, shift right
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[AW-1:1]};

  // Restoring divide step: shift left, subtract divisor if it fits
  logic [XLEN:0]   div_part;
  logic [XLEN:0]   div_diff;
  logic            div_fit;
  logic [AW-1:0]   div_next;

  assign div_part = acc_q[AW-1:XLEN-1];
  assign div_diff = div_part - {1'b0, opnd_q};
  assign div_fit  = (div_part >= {1'b0, opnd_q});
  assign div_next = div_fit ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                            : {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  // Sign correction and result selection
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? (~acc_q + AW'(1)) : acc_q;
  assign quo_fix  = bzero_q ? '1
                  : (neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0]);
  assign rem_fix  = neg_rem_q ? (~acc_q[AW-1:XLEN] + XLEN'(1)) : acc_q[AW-1:XLEN];

  always_comb begin
    fix_res = acc_q[XLEN-1:0];
    case (f3_q)
      3'b000:                 fix_res = acc_q[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[AW-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    result_d  = result_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d      = funct3;
          cnt_d     = '0;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          bzero_d   = (op_b == '0);
          if (funct3[2]) begin
            opnd_d = b_mag;
            acc_d  = {XLEN'(0), a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {XLEN'(0), b_mag};
          end
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        acc_d   = {XLEN'(0), fix_res};
        state_d = S_DONE;
      end
      default: begin
        done_d   = 1'b1;
        result_d = acc_q[XLEN-1:0];
        state_d  = S_IDLE;
      end
    endcase

    // Pipeline kill: drop everything in flight, keep the last result
    if (flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: self-checking bench for riscv_muldiv at XLEN=32.
// It covers directed vectors, fixed latency, flush/start/reset corner cases,
// and random operations checked against an arithmetic reference model.
module tb_riscv_muldiv;

  localparam int unsigned XLEN = 32;
  localparam int          LAT  = 34;
  localparam int          BUSY = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_muldiv #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics using plain wide integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f)
      3'b000: begin p = 64'(ua * ub); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Present one start pulse; returns positioned 1 time unit after the accepting edge
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded); also counts busy-high samples
  task automatic wait_done(input string name, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_100", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat,
                        output int bcnt);
    launch(f, a, b);
    wait_done(name, lat, bcnt);
    res = result;
  endtask

  // Watch for any done pulse over n cycles
  task automatic expect_no_done(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  vec_t        vecs[12];
  logic [31:0] res, prior, exp;
  logic [2:0]  rf;
  logic [31:0] ra, rb;
  int          lat, bcnt, total;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC};
    vecs[7]  = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[8]  = '{3'b111, 32'd5,          32'd0,          32'd5};
    vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[11] = '{3'b000, 32'd3,          32'd4,          32'd12};

    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    op_a   = '0;
    op_b   = '0;

    // Reset state
    #12;
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bcnt);
      check($sformatf("vec%0d_result", i),  64'(res),  64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat),  64'(LAT));
      check($sformatf("vec%0d_busy", i),    64'(bcnt), 64'(BUSY));
    end
    prior = 32'd12;

    // done is a single-cycle pulse and result holds afterwards
    @(posedge clk);
    #1;
    check("done_pulse_width", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("result_hold", 64'(result), 64'(prior));

    // Flush at calc cycle 10
    launch(3'b101, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",   64'(busy),   64'd0);
    check("flush_done",   64'(done),   64'd0);
    check("flush_result", 64'(result), 64'(prior));
    expect_no_done("flush_no_done", 40);
    check("flush_result_after", 64'(result), 64'(prior));

    // Start pulsed while busy is ignored
    launch(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    funct3 = 3'b100;
    op_a   = 32'd1;
    op_b   = 32'd1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", lat, bcnt);
    total = 6 + lat;
    check("busy_start_result",  64'(result), 64'(ref_model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0)));
    check("busy_start_latency", 64'(total),  64'(LAT));
    prior = ref_model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);

    // Simultaneous flush and start while idle
    @(negedge clk);
    funct3 = 3'b000;
    op_a   = 32'd5;
    op_b   = 32'd5;
    start  = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    expect_no_done("flush_start_no_done", 40);
    check("flush_start_result", 64'(result), 64'(prior));

    // Asynchronous reset in the middle of calc
    launch(3'b000, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_busy",   64'(busy),   64'd0);
    check("async_reset_done",   64'(done),   64'd0);
    check("async_reset_result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_no_done("async_reset_no_done", 40);
    run_op("post_reset_mul", 3'b000, 32'd3, 32'd4, res, lat, bcnt);
    check("post_reset_mul_result",  64'(res), 64'd12);
    check("post_reset_mul_latency", 64'(lat), 64'(LAT));

    // Random operations against the reference model
    for (int i = 0; i < 300; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      exp = ref_model(rf, ra, rb);
      run_op($sformatf("rand%0d", i), rf, ra, rb, res, lat, bcnt);
      if (res !== exp || lat != LAT) begin
        $display("  rand%0d op=%0d a=0x%08h b=0x%08h lat=%0d", i, rf, ra, rb, lat);
      end
      check($sformatf("rand%0d_result", i),  64'(res), 64'(exp));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(LAT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
